burst_r_serializer: RTL and testbench

//  Downstream stage of the whole-burst FIFO. Pops one stored RESPONSE record
//  (kind=1) at a time and replays it as AXI R-channel beats.

---
 rtl/burst_r_serializer.sv | 135 +++++++++++++
 tb/tb_burst_r_serializer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_r_serializer.sv
// Replays whole-burst RESPONSE records from the burst FIFO head as AXI R-channel beats.
// Request and malformed records are popped, dropped and flagged on err_drop.
module burst_r_serializer #(
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BEATS  = 32,
   localparam int NB_W      = $clog2(MAX_BEATS + 1),
   localparam int PAY_W     = MAX_BEATS * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic                  fifo_kind,
   input  logic [7:0]            fifo_id,
   input  logic [1:0]            fifo_rresp,
   input  logic [NB_W-1:0]       fifo_nbeats,
   input  logic [PAY_W-1:0]      fifo_payload,
   input  logic [7:0]            fifo_tag,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [7:0]            rid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic [7:0]            rtag,
   output logic                  busy,
   output logic                  err_drop
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t                  state_r;
   logic [NB_W-1:0]         beat_cnt_r;
   logic [NB_W-1:0]         nbeats_r;
   logic [PAY_W-1:0]        payload_r;
   logic [7:0]              id_r;
   logic [1:0]              rresp_r;
   logic [7:0]              tag_r;
   logic [DATA_WIDTH-1:0]   rdata_r;
   logic                    rlast_r;
   logic                    err_drop_r;

   logic                    xfer_s;
   logic                    load_s;
   logic                    accept_s;
   logic [NB_W-1:0]         next_cnt_s;

   function automatic logic [DATA_WIDTH-1:0] beat_of(input logic [PAY_W-1:0] pay,
                                                     input logic [NB_W-1:0]  idx);
      beat_of = pay[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
   endfunction

   // Handshake, pop and record-validity decode; pops are suppressed while in reset
   always_comb begin
      xfer_s     = 1'b0;
      load_s     = 1'b0;
      accept_s   = 1'b0;
      next_cnt_s = beat_cnt_r + {{(NB_W-1){1'b0}}, 1'b1};
      xfer_s     = (state_r == ST_STREAM) & rready;
      load_s     = rst & ~fifo_empty & ((state_r == ST_IDLE) | (xfer_s & rlast_r));
      accept_s   = fifo_kind & (fifo_nbeats != {NB_W{1'b0}})
                   & (fifo_nbeats <= NB_W'(MAX_BEATS));
   end

   // Burst FSM with registered R-channel outputs; the next beat is pre-selected on each transfer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         beat_cnt_r <= {NB_W{1'b0}};
         nbeats_r   <= {NB_W{1'b0}};
         payload_r  <= {PAY_W{1'b0}};
         id_r       <= 8'h00;
         rresp_r    <= 2'b00;
         tag_r      <= 8'h00;
         rdata_r    <= {DATA_WIDTH{1'b0}};
         rlast_r    <= 1'b0;
         err_drop_r <= 1'b0;
      end else begin
         err_drop_r <= 1'b0;
         if (load_s) begin
            if (accept_s) begin
               state_r    <= ST_STREAM;
               beat_cnt_r <= {NB_W{1'b0}};
               nbeats_r   <= fifo_nbeats;
               payload_r  <= fifo_payload;
               id_r       <= fifo_id;
               rresp_r    <= fifo_rresp;
               tag_r      <= fifo_tag;
               rdata_r    <= fifo_payload[DATA_WIDTH-1:0];
               rlast_r    <= (fifo_nbeats == {{(NB_W-1){1'b0}}, 1'b1});
            end else begin
               state_r    <= ST_IDLE;
               rlast_r    <= 1'b0;
               err_drop_r <= 1'b1;
            end
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
               end
               ST_STREAM: begin
                  if (xfer_s && rlast_r) begin
                     state_r <= ST_IDLE;
                     rlast_r <= 1'b0;
                  end else if (xfer_s) begin
                     beat_cnt_r <= next_cnt_s;
                     rdata_r    <= beat_of(payload_r, next_cnt_s);
                     rlast_r    <= (next_cnt_s == (nbeats_r - {{(NB_W-1){1'b0}}, 1'b1}));
                  end else begin
                     state_r <= ST_STREAM;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  rlast_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign fifo_rd_en = load_s;
   assign rvalid     = (state_r == ST_STREAM);
   assign busy       = (state_r == ST_STREAM);
   assign rid        = id_r;
   assign rdata      = rdata_r;
   assign rresp      = rresp_r;
   assign rlast      = rlast_r;
   assign rtag       = tag_r;
   assign err_drop   = err_drop_r;

endmodule

// File: tb/tb_burst_r_serializer.sv
// Directed bench for burst_r_serializer: a FIFO model feeds records and a
// beat scoreboard filled at push time is checked against every R transfer.
module tb_burst_r_serializer;

   localparam int DW  = 64;
   localparam int MB  = 32;
   localparam int NBW = 6;
   localparam int PW  = MB * DW;

   typedef struct {
      logic           kind;
      logic [7:0]     id;
      logic [1:0]     rresp;
      logic [NBW-1:0] nbeats;
      logic [PW-1:0]  payload;
      logic [7:0]     tag;
   } rec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [7:0]    id;
      logic [1:0]    rresp;
      logic          last;
      logic [7:0]    tag;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           fifo_empty;
   logic           fifo_rd_en;
   logic           fifo_kind;
   logic [7:0]     fifo_id;
   logic [1:0]     fifo_rresp;
   logic [NBW-1:0] fifo_nbeats;
   logic [PW-1:0]  fifo_payload;
   logic [7:0]     fifo_tag;
   logic           rvalid;
   logic           rready;
   logic [7:0]     rid;
   logic [DW-1:0]  rdata;
   logic [1:0]     rresp;
   logic           rlast;
   logic [7:0]     rtag;
   logic           busy;
   logic           err_drop;

   rec_t  mem [64];
   int    wr_ptr = 0;
   int    rd_ptr = 0;
   beat_t exp_q [$];
   int    xfer_log [$];
   int    checks = 0;
   int    fails = 0;
   int    cyc = 0;
   int    xfers = 0;
   int    err_seen = 0;
   logic  prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic  prev_last = 1'b0;
   logic  toggle_mode = 1'b0;
   logic [3:0] pat = 4'b1001;

   burst_r_serializer #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_kind(fifo_kind), .fifo_id(fifo_id), .fifo_rresp(fifo_rresp),
      .fifo_nbeats(fifo_nbeats), .fifo_payload(fifo_payload), .fifo_tag(fifo_tag),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rtag(rtag), .busy(busy), .err_drop(err_drop)
   );

   always #5 clk = ~clk;

   assign fifo_empty   = (rd_ptr == wr_ptr);
   assign fifo_kind    = mem[rd_ptr].kind;
   assign fifo_id      = mem[rd_ptr].id;
   assign fifo_rresp   = mem[rd_ptr].rresp;
   assign fifo_nbeats  = mem[rd_ptr].nbeats;
   assign fifo_payload = mem[rd_ptr].payload;
   assign fifo_tag     = mem[rd_ptr].tag;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [PW-1:0] mk_pl(input logic [63:0] base, input int n);
      mk_pl = '0;
      for (int k = 0; k < n; k++) mk_pl[k*DW +: DW] = base + 64'(k);
   endfunction

   task automatic push_rec(input logic kind, input logic [7:0] id, input logic [1:0] rr,
                           input logic [NBW-1:0] nb, input logic [PW-1:0] pl,
                           input logic [7:0] tag);
      beat_t b;
      mem[wr_ptr].kind    = kind;
      mem[wr_ptr].id      = id;
      mem[wr_ptr].rresp   = rr;
      mem[wr_ptr].nbeats  = nb;
      mem[wr_ptr].payload = pl;
      mem[wr_ptr].tag     = tag;
      wr_ptr++;
      if (kind && nb >= 1 && nb <= MB) begin
         for (int k = 0; k < int'(nb); k++) begin
            b.data  = pl[k*DW +: DW];
            b.id    = id;
            b.rresp = rr;
            b.last  = (k == int'(nb) - 1);
            b.tag   = tag;
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || rvalid === 1'b1 || rd_ptr != wr_ptr) && n < budget) begin
         @(posedge clk); #1;
         rready = toggle_mode ? pat[cyc % 4] : 1'b1;
         n++;
      end
      check("drain_within_budget", 64'(n < budget), 64'(1));
   endtask

   // R-channel monitor: scoreboard compare on transfer, hold check across stalls
   always @(negedge clk) begin
      if (rst) begin
         if (prev_stall) begin
            check("stall_rvalid_hold", 64'(rvalid), 64'(1));
            check("stall_rdata_hold", rdata, prev_data);
            check("stall_rlast_hold", 64'(rlast), 64'(prev_last));
         end
         if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(exp_q.size()), 64'(1));
            end else begin
               check("beat_rdata", rdata, exp_q[0].data);
               check("beat_rid", 64'(rid), 64'(exp_q[0].id));
               check("beat_rresp", 64'(rresp), 64'(exp_q[0].rresp));
               check("beat_rlast", 64'(rlast), 64'(exp_q[0].last));
               check("beat_rtag", 64'(rtag), 64'(exp_q[0].tag));
               void'(exp_q.pop_front());
            end
            xfer_log.push_back(cyc);
            xfers <= xfers + 1;
         end
         if (err_drop) err_seen <= err_seen + 1;
         prev_stall <= rvalid & ~rready;
         prev_data  <= rdata;
         prev_last  <= rlast;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   initial begin
      int base;
      int e0;
      int x0;
      int n;
      logic [PW-1:0] pl;
      rst    = 1'b0;
      rready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rvalid", 64'(rvalid), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_rlast", 64'(rlast), 64'(0));
      check("reset_err_drop", 64'(err_drop), 64'(0));
      check("reset_rdata", rdata, 64'(0));
      check("reset_rid", 64'(rid), 64'(0));
      check("reset_rd_en", 64'(fifo_rd_en), 64'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      // single 4-beat burst, sink always ready
      rready = 1'b1;
      base = rd_ptr;
      push_rec(1'b1, 8'h05, 2'b00, 6'd4, mk_pl(64'hA0, 4), 8'h11);
      @(negedge clk);
      check("t1_rd_en", 64'(fifo_rd_en), 64'(1));
      @(posedge clk); #1;
      check("t1_latency_rvalid", 64'(rvalid), 64'(1));
      check("t1_first_rdata", rdata, 64'hA0);
      check("t1_busy", 64'(busy), 64'(1));
      drain(100);
      check("t1_single_pop", 64'(rd_ptr - base), 64'(1));

      // same burst, sink toggling 1,0,0,1
      x0 = xfers;
      toggle_mode = 1'b1;
      push_rec(1'b1, 8'h05, 2'b10, 6'd4, mk_pl(64'hA0, 4), 8'h22);
      drain(100);
      toggle_mode = 1'b0;
      rready = 1'b1;
      check("t2_transfer_count", 64'(xfers - x0), 64'(4));

      // two queued records stream back to back
      @(posedge clk); #1;
      xfer_log.delete();
      push_rec(1'b1, 8'h31, 2'b01, 6'd2, mk_pl(64'hB0, 2), 8'h33);
      push_rec(1'b1, 8'h32, 2'b11, 6'd1, mk_pl(64'hB8, 1), 8'h34);
      drain(100);
      check("t3_beat_count", 64'(xfer_log.size()), 64'(3));
      if (xfer_log.size() == 3)
         check("t3_no_bubble", 64'(xfer_log[2] - xfer_log[0]), 64'(2));

      // request record dropped, then a single-beat response
      e0 = err_seen;
      x0 = xfers;
      push_rec(1'b0, 8'h40, 2'b00, 6'd2, mk_pl(64'hC0, 2), 8'h41);
      push_rec(1'b1, 8'h42, 2'b00, 6'd1, mk_pl(64'hC8, 1), 8'h43);
      drain(100);
      check("t4_err_drop_count", 64'(err_seen - e0), 64'(1));
      check("t4_transfer_count", 64'(xfers - x0), 64'(1));

      // nbeats boundaries: 0 and MAX+1 dropped, MAX streamed
      e0 = err_seen;
      x0 = xfers;
      pl = '0;
      for (int k = 0; k < MB; k++) pl[k*DW +: DW] = {$urandom, $urandom};
      push_rec(1'b1, 8'h50, 2'b00, 6'd0, pl, 8'h51);
      push_rec(1'b1, 8'h52, 2'b00, 6'd33, pl, 8'h53);
      push_rec(1'b1, 8'h54, 2'b01, 6'd32, pl, 8'h55);
      drain(200);
      check("t5_err_drop_count", 64'(err_seen - e0), 64'(2));
      check("t5_transfer_count", 64'(xfers - x0), 64'(32));

      // asynchronous reset in the middle of a burst
      x0 = xfers;
      push_rec(1'b1, 8'h60, 2'b00, 6'd4, mk_pl(64'hE0, 4), 8'h61);
      n = 0;
      while (xfers - x0 < 2 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check("t6_reach_beat2", 64'(n < 50), 64'(1));
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("t6_rst_rvalid", 64'(rvalid), 64'(0));
      check("t6_rst_busy", 64'(busy), 64'(0));
      check("t6_rst_rdata", rdata, 64'(0));
      check("t6_rst_rlast", 64'(rlast), 64'(0));
      check("t6_rst_rid", 64'(rid), 64'(0));
      check("t6_rst_rtag", 64'(rtag), 64'(0));
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      check("t6_idle_after_release", 64'(busy), 64'(0));
      check("t6_no_repop", 64'(rd_ptr), 64'(wr_ptr));
      x0 = xfers;
      push_rec(1'b1, 8'h70, 2'b00, 6'd3, mk_pl(64'hF0, 3), 8'h71);
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_restart_beat0", rdata, 64'hF0);
      drain(100);
      check("t6_transfer_count", 64'(xfers - x0), 64'(3));
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
